// File: rtl/slotmaker_pkg.sv
// Shared types for the slotmaker configuration path: slot/card widths and the
// configuration sequencer state encoding.
package slotmaker_pkg;

    localparam int unsigned NUM_SLOTS = 8;
    localparam int unsigned SLOT_W    = 3;
    localparam int unsigned CARD_W    = 8;

    typedef logic [SLOT_W-1:0] slot_t;
    typedef logic [CARD_W-1:0] card_t;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD,
        CAP,
        WR,
        DONE
    } cfg_state_t;

    // Slot n of a packed card map lives in bits [8n+7:8n].
    function automatic card_t default_card(logic [63:0] map, slot_t slot);
        return map[{slot, 3'b000} +: CARD_W];
    endfunction

endpackage

// File: rtl/slot_cfg_rr_arb.sv
// Combinational round-robin pick: first requester at or after ptr+1 (mod NUM_REQ).
module slot_cfg_rr_arb #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            idx = IDX_W'((int'(ptr) + 1 + i) % int'(NUM_REQ));
            if (!valid && req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/slot_cfg_arbiter.sv
// Sequences the slotmaker configuration port: default sweep after reset, then
// round-robin shared read / read-modify-write access with change reporting.
module slot_cfg_arbiter
    import slotmaker_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 2,
    parameter logic [63:0] DEFAULT_CARDS = 64'h0,
    parameter bit          PROTECT_SLOT0 = 1'b1
) (
    input  logic                           clk_logic,
    input  logic                           system_reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ-1:0][SLOT_W-1:0] req_slot,
    input  logic [NUM_REQ-1:0][CARD_W-1:0] req_card,
    output logic [NUM_REQ-1:0]             done,
    output logic [CARD_W-1:0]              rdata,
    output logic                           err,
    output logic [SLOT_W-1:0]              cfg_slot,
    output logic                           cfg_wr,
    output logic [CARD_W-1:0]              cfg_card_i,
    input  logic [CARD_W-1:0]              cfg_card_o,
    output logic                           init_done,
    output logic                           chg_valid,
    output logic [SLOT_W-1:0]              chg_slot,
    output logic [CARD_W-1:0]              chg_card
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    cfg_state_t       state;
    logic [3:0]       cnt;
    logic [IDX_W-1:0] ptr;
    logic             we_q;
    slot_t            slot_q;
    card_t            card_q;
    card_t            old_q;

    logic [IDX_W-1:0] arb_grant;
    logic             arb_valid;

    slot_cfg_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    always_ff @(posedge clk_logic) begin
        if (system_reset) begin
            state      <= INIT;
            cnt        <= '0;
            ptr        <= IDX_W'(NUM_REQ - 1);
            we_q       <= 1'b0;
            slot_q     <= '0;
            card_q     <= '0;
            old_q      <= '0;
            done       <= '0;
            rdata      <= '0;
            err        <= 1'b0;
            cfg_slot   <= '0;
            cfg_wr     <= 1'b0;
            cfg_card_i <= '0;
            init_done  <= 1'b0;
            chg_valid  <= 1'b0;
            chg_slot   <= '0;
            chg_card   <= '0;
        end else begin
            done      <= '0;
            err       <= 1'b0;
            cfg_wr    <= 1'b0;
            chg_valid <= 1'b0;
            unique case (state)
                INIT: begin
                    if (cnt[3]) begin
                        init_done <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cfg_wr     <= 1'b1;
                        cfg_slot   <= cnt[2:0];
                        cfg_card_i <= default_card(DEFAULT_CARDS, cnt[2:0]);
                        cnt        <= cnt + 4'd1;
                    end
                end
                IDLE: begin
                    if (arb_valid) begin
                        ptr      <= arb_grant;
                        we_q     <= req_we[arb_grant];
                        slot_q   <= req_slot[arb_grant];
                        card_q   <= req_card[arb_grant];
                        cfg_slot <= req_slot[arb_grant];
                        state    <= RD;
                    end
                end
                RD: state <= CAP;
                CAP: begin
                    // cfg_card_o now reflects cfg_slot from the previous cycle
                    old_q <= cfg_card_o;
                    if (!we_q) begin
                        done[ptr] <= 1'b1;
                        rdata     <= cfg_card_o;
                        state     <= DONE;
                    end else if (PROTECT_SLOT0 && slot_q == '0) begin
                        done[ptr] <= 1'b1;
                        rdata     <= cfg_card_o;
                        err       <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cfg_wr     <= 1'b1;
                        cfg_card_i <= card_q;
                        state      <= WR;
                    end
                end
                WR: begin
                    done[ptr] <= 1'b1;
                    rdata     <= card_q;
                    chg_valid <= (old_q != card_q);
                    chg_slot  <= slot_q;
                    chg_card  <= card_q;
                    state     <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_slot_cfg_arbiter.sv
// Self-checking bench for slot_cfg_arbiter with a behavioural slotmaker cfg port.
module tb_slot_cfg_arbiter;

    localparam logic [63:0] DEF  = 64'h0000_0000_0203_0400;
    localparam bit          PROT = 1'b1;

    logic            clk_logic = 1'b0;
    logic            system_reset = 1'b1;
    logic [1:0]      req = '0;
    logic [1:0]      req_we = '0;
    logic [1:0][2:0] req_slot = '0;
    logic [1:0][7:0] req_card = '0;
    logic [1:0]      done;
    logic [7:0]      rdata;
    logic            err;
    logic [2:0]      cfg_slot;
    logic            cfg_wr;
    logic [7:0]      cfg_card_i;
    logic [7:0]      cfg_card_o = '0;
    logic            init_done;
    logic            chg_valid;
    logic [2:0]      chg_slot;
    logic [7:0]      chg_card;

    always #5 clk_logic = ~clk_logic;

    slot_cfg_arbiter #(
        .NUM_REQ       (2),
        .DEFAULT_CARDS (DEF),
        .PROTECT_SLOT0 (PROT)
    ) dut (
        .clk_logic    (clk_logic),
        .system_reset (system_reset),
        .req          (req),
        .req_we       (req_we),
        .req_slot     (req_slot),
        .req_card     (req_card),
        .done         (done),
        .rdata        (rdata),
        .err          (err),
        .cfg_slot     (cfg_slot),
        .cfg_wr       (cfg_wr),
        .cfg_card_i   (cfg_card_i),
        .cfg_card_o   (cfg_card_o),
        .init_done    (init_done),
        .chg_valid    (chg_valid),
        .chg_slot     (chg_slot),
        .chg_card     (chg_card)
    );

    // Slotmaker stand-in: registered readout, write on cfg_wr.
    logic [7:0] mem [8];
    initial for (int i = 0; i < 8; i++) mem[i] = 8'hAA;
    always @(posedge clk_logic) begin
        cfg_card_o <= mem[cfg_slot];
        if (cfg_wr) mem[cfg_slot] <= cfg_card_i;
    end

    typedef struct {
        int         idx;
        logic [2:0] slot;
        logic [7:0] rdata;
        bit         chk_rd;
        logic       err;
        logic       chg;
        logic [7:0] card;
        int         wr_cyc;
        int         done_cyc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ref_map [8];
    int         rem [2];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;

    task automatic tick();
        @(posedge clk_logic);
        #1;
        cyc++;
    endtask

    task automatic reset_ref();
        logic [63:0] d;
        d = DEF;
        for (int i = 0; i < 8; i++) ref_map[i] = d[8*i +: 8];
    endtask

    task automatic drive_req(input int idx, input bit we, input logic [2:0] slot,
                             input logic [7:0] card, input int n);
        req[idx]      = 1'b1;
        req_we[idx]   = we;
        req_slot[idx] = slot;
        req_card[idx] = card;
        rem[idx]      = n;
    endtask

    // Predict one operation in grant order and advance the reference card map.
    task automatic push_op(input int idx, input bit we, input logic [2:0] slot,
                           input logic [7:0] card, input int t0);
        exp_t e;
        bit   rej;
        bit   wr;
        rej        = we && PROT && (slot == 3'd0);
        wr         = we && !rej;
        e.idx      = idx;
        e.slot     = slot;
        e.rdata    = wr ? card : ref_map[slot];
        e.chk_rd   = !rej;
        e.err      = rej;
        e.chg      = wr && (ref_map[slot] != card);
        e.card     = card;
        e.wr_cyc   = wr ? t0 + 3 : -1;
        e.done_cyc = t0 + (wr ? 4 : 3);
        if (wr) ref_map[slot] = card;
        sb.push_back(e);
    endtask

    // Advance until the scoreboard drains, then step into the following IDLE cycle.
    task automatic run_ops(input int budget);
        exp_t e;
        int   n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            tick();
            n++;
            vectors++;
            if (cfg_wr !== (cyc == sb[0].wr_cyc)) begin
                miscompares++;
                $display("FAIL cfg_wr cyc=%0d got=%b exp=%b", cyc, cfg_wr, cyc == sb[0].wr_cyc);
            end
            if (cyc == sb[0].wr_cyc) begin
                vectors++;
                if (cfg_slot !== sb[0].slot || cfg_card_i !== sb[0].card) begin
                    miscompares++;
                    $display("FAIL wr_port cyc=%0d got=%0d/%h exp=%0d/%h", cyc, cfg_slot,
                             cfg_card_i, sb[0].slot, sb[0].card);
                end
            end
            if (done !== 2'b00) begin
                e = sb.pop_front();
                vectors++;
                if (done !== 2'(1 << e.idx) || cyc != e.done_cyc) begin
                    miscompares++;
                    $display("FAIL done cyc=%0d got=%b exp=%b@%0d", cyc, done,
                             2'(1 << e.idx), e.done_cyc);
                end
                vectors++;
                if (err !== e.err || (e.chk_rd && rdata !== e.rdata)) begin
                    miscompares++;
                    $display("FAIL rdata_err got=%h/%b exp=%h/%b", rdata, err, e.rdata, e.err);
                end
                vectors++;
                if (chg_valid !== e.chg ||
                    (e.chg && (chg_slot !== e.slot || chg_card !== e.card))) begin
                    miscompares++;
                    $display("FAIL chg got=%b/%0d/%h exp=%b/%0d/%h", chg_valid, chg_slot,
                             chg_card, e.chg, e.slot, e.card);
                end
                for (int i = 0; i < 2; i++) begin
                    if (done[i]) begin
                        rem[i]--;
                        if (rem[i] <= 0) req[i] = 1'b0;
                    end
                end
            end else if (chg_valid !== 1'b0) begin
                vectors++;
                miscompares++;
                $display("FAIL chg_idle cyc=%0d got=%b exp=0", cyc, chg_valid);
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL timeout pending=%0d exp=0", sb.size());
            sb.delete();
            req = '0;
        end
        tick();
    endtask

    // Expects cyc==0 in the window where reset was just released.
    task automatic check_sweep();
        logic [63:0] d;
        d = DEF;
        for (int k = 0; k < 8; k++) begin
            tick();
            vectors++;
            if (cfg_wr !== 1'b1 || cfg_slot !== 3'(k) || cfg_card_i !== d[8*k +: 8] ||
                init_done !== 1'b0 || done !== 2'b00) begin
                miscompares++;
                $display("FAIL sweep cyc=%0d got=%b/%0d/%h/%b/%b exp=1/%0d/%h/0/00", cyc,
                         cfg_wr, cfg_slot, cfg_card_i, init_done, done, k, d[8*k +: 8]);
            end
        end
        tick();
        vectors++;
        if (cfg_wr !== 1'b0 || init_done !== 1'b1 || done !== 2'b00) begin
            miscompares++;
            $display("FAIL sweep_end cyc=%0d got=%b/%b/%b exp=0/1/00", cyc, cfg_wr,
                     init_done, done);
        end
    endtask

    task automatic test_reset();
        system_reset = 1'b1;
        drive_req(1, 1'b0, 3'd1, 8'h00, 1);
        tick();
        tick();
        vectors++;
        if (done !== 2'b00 || rdata !== 8'h00 || err !== 1'b0 || cfg_wr !== 1'b0 ||
            cfg_slot !== 3'd0 || cfg_card_i !== 8'h00 || init_done !== 1'b0 ||
            chg_valid !== 1'b0 || chg_slot !== 3'd0 || chg_card !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_vals got=%b/%h/%b/%b/%0d/%h/%b/%b exp=all zero", done, rdata,
                     err, cfg_wr, cfg_slot, cfg_card_i, init_done, chg_valid);
        end
        system_reset = 1'b0;
        cyc = 0;
        reset_ref();
        check_sweep();
        push_op(1, 1'b0, 3'd1, 8'h00, cyc);
        run_ops(40);
    endtask

    task automatic test_read();
        drive_req(0, 1'b0, 3'd2, 8'h00, 1);
        push_op(0, 1'b0, 3'd2, 8'h00, cyc);
        tick();
        vectors++;
        if (cfg_slot !== 3'd2) begin
            miscompares++;
            $display("FAIL rd_slot got=%0d exp=2", cfg_slot);
        end
        run_ops(40);
    endtask

    task automatic test_write();
        for (int r = 0; r < 2; r++) begin
            drive_req(0, 1'b1, 3'd4, 8'h05, 1);
            push_op(0, 1'b1, 3'd4, 8'h05, cyc);
            run_ops(40);
        end
    endtask

    task automatic test_protect();
        drive_req(0, 1'b1, 3'd0, 8'h07, 1);
        push_op(0, 1'b1, 3'd0, 8'h07, cyc);
        run_ops(40);
        drive_req(1, 1'b0, 3'd0, 8'h00, 1);
        push_op(1, 1'b0, 3'd0, 8'h00, cyc);
        run_ops(40);
    endtask

    task automatic test_back_to_back();
        int c;
        c = cyc;
        drive_req(0, 1'b0, 3'd3, 8'h00, 2);
        drive_req(1, 1'b0, 3'd1, 8'h00, 1);
        push_op(0, 1'b0, 3'd3, 8'h00, c);
        push_op(1, 1'b0, 3'd1, 8'h00, c + 4);
        push_op(0, 1'b0, 3'd3, 8'h00, c + 8);
        run_ops(60);
    endtask

    task automatic test_reset_midop();
        drive_req(1, 1'b1, 3'd5, 8'h09, 1);
        tick();
        tick();
        system_reset = 1'b1;
        tick();
        vectors++;
        if (done !== 2'b00 || cfg_wr !== 1'b0 || chg_valid !== 1'b0 || init_done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort got=%b/%b/%b/%b exp=00/0/0/0", done, cfg_wr, chg_valid,
                     init_done);
        end
        system_reset = 1'b0;
        cyc = 0;
        reset_ref();
        check_sweep();
        push_op(1, 1'b1, 3'd5, 8'h09, cyc);
        run_ops(40);
        drive_req(0, 1'b0, 3'd4, 8'h00, 1);
        push_op(0, 1'b0, 3'd4, 8'h00, cyc);
        run_ops(40);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_protect();
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
